// File: rtl/fpga_spi_cmd_responder.sv
// fpga_spi_cmd_responder: SPI mode-0 slave that decodes START / WRITE_REG / READ_REG
// word transactions from the flight-computer master and drives memory-map strobes.
// All logic runs on clk210_p. SPI pins are 2-FF synchronised and edge-detected.
// Optional feature macro: SPI_RESP_TIMEOUT_EN (stall watchdog aborting a transaction
// after TIMEOUT_CYC idle cycles with SS low).
`timescale 1ns/1ps
module fpga_spi_cmd_responder #(
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic        spi_sck_p,
  input  logic        spi_mosi_p,
  input  logic        spi_ss_p,
  output logic        spi_miso_p,
  output logic [15:0] mm_rd_addr_p,
  output logic        mm_rd_en_p,
  input  logic [15:0] mm_rd_data_p,
  output logic [15:0] mm_wr_addr_p,
  output logic [15:0] mm_wr_data_p,
  output logic        mm_wr_en_p,
  output logic        spi_busy_p,
  output logic        spi_err_p
);

  localparam logic [15:0] START_W   = 16'd1;
  localparam logic [15:0] WRITE_W   = 16'd2;
  localparam logic [15:0] READ_W    = 16'd3;
  localparam logic [15:0] SUCCESS_W = 16'd20;
  localparam logic [15:0] STOP_W    = 16'd22;
  localparam logic [15:0] UNSUCC_W  = 16'd27;
  localparam logic [3:0]  RD_LAT_W  = 4'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_MMRD  = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5,
    S_DRAIN = 3'd6
  } state_e;

  logic [2:0]  sck_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [1:0]  ss_sync_q;
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic        is_read_q, is_read_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  wait_q, wait_d;
  logic        miso_q, miso_d;
  logic        rd_en_q, rd_en_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        sck_rise_s, sck_fall_s, mosi_s, ss_high_s;
  logic        word_done_s, active_s, abort_s, timeout_s, sck_ok_s;
  logic [15:0] word_s;

`ifdef SPI_RESP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ignore_q, ignore_d;
`else
  logic [31:0] unused_tmo_s;
  assign unused_tmo_s = 32'(TIMEOUT_CYC);
`endif

  assign sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s = ~sck_sync_q[1] & sck_sync_q[2];
  assign mosi_s     = mosi_sync_q[1];
  assign ss_high_s  = ss_sync_q[1];

  // Synchronise the asynchronous SPI pins; third SCK stage gives edge detection.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 2'b11;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck_p};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_p};
      ss_sync_q   <= {ss_sync_q[0], spi_ss_p};
    end
  end

  // Bit layer, abort handling, transaction FSM and output next-state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    word_done_s = 1'b0;
    word_s      = {rx_q[14:0], mosi_s};
    active_s    = (state_q != S_IDLE) || (bit_cnt_q != 4'd0);
    timeout_s   = 1'b0;
    sck_ok_s    = 1'b1;
`ifdef SPI_RESP_TIMEOUT_EN
    tmo_d    = tmo_q;
    ignore_d = ignore_q & ~ss_high_s;
    sck_ok_s = ~ignore_q;
    if (sck_rise_s || sck_fall_s || ss_high_s || !active_s || ignore_q) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q == TMO_LIMIT) begin
      timeout_s = 1'b1;
      ignore_d  = 1'b1;
      tmo_d     = {TMO_W{1'b0}};
    end else begin
      tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
`endif
    abort_s = (ss_high_s && active_s) || timeout_s;

    if (abort_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      rx_d      = 16'd0;
      tx_d      = 16'd0;
      wait_d    = 4'd0;
      err_d     = 1'b1;
    end else begin
      if (!ss_high_s && sck_ok_s) begin
        if (sck_rise_s) begin
          rx_d        = word_s;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          word_done_s = (bit_cnt_q == 4'd15);
        end else if (sck_fall_s && (bit_cnt_q != 4'd0)) begin
          // The fall after the 16th rise (count wrapped) must not disturb a freshly loaded response.
          tx_d = {tx_q[14:0], 1'b0};
        end else begin
          tx_d = tx_q;
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end

      case (state_q)
        S_IDLE: begin
          if (word_done_s) begin
            if (word_s == START_W) begin
              state_d = S_CMD;
              tx_d    = SUCCESS_W;
            end else begin
              state_d = S_DRAIN;
              tx_d    = UNSUCC_W;
              err_d   = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (word_done_s) begin
            if ((word_s == WRITE_W) || (word_s == READ_W)) begin
              is_read_d = (word_s == READ_W);
              state_d   = S_ADDR;
              tx_d      = SUCCESS_W;
            end else begin
              state_d = S_DRAIN;
              tx_d    = UNSUCC_W;
              err_d   = 1'b1;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_ADDR: begin
          if (word_done_s) begin
            addr_d = word_s;
            tx_d   = SUCCESS_W;
            if (is_read_q) begin
              state_d   = S_MMRD;
              rd_en_d   = 1'b1;
              rd_addr_d = word_s;
              wait_d    = 4'd0;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_MMRD: begin
          // Strobe was high on entry (wait=0); data is valid RD_LAT cycles later.
          if (wait_q == RD_LAT_W) begin
            tx_d    = mm_rd_data_p;
            state_d = S_DATA;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        S_DATA: begin
          if (word_done_s) begin
            if (!is_read_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = word_s;
            end else begin
              wr_en_d = 1'b0;
            end
            tx_d    = STOP_W;
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end
        S_STOP, S_DRAIN: begin
          if (word_done_s) begin
            tx_d    = 16'd0;
            state_d = S_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 16'd0;
        end
      endcase
    end

    miso_d = ~ss_high_s & tx_d[15];
    busy_d = (state_d != S_IDLE) || (bit_cnt_d != 4'd0);
  end

  // State and registered outputs; reset discards any transaction in flight.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 16'd0;
      tx_q      <= 16'd0;
      is_read_q <= 1'b0;
      addr_q    <= 16'd0;
      wait_q    <= 4'd0;
      miso_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 16'd0;
      wr_data_q <= 16'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      miso_q    <= miso_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

`ifdef SPI_RESP_TIMEOUT_EN
  // Stall watchdog counter and post-timeout SCK blanking until SS deasserts.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      tmo_q    <= {TMO_W{1'b0}};
      ignore_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      ignore_q <= ignore_d;
    end
  end
`endif

  assign spi_miso_p   = miso_q;
  assign mm_rd_addr_p = rd_addr_q;
  assign mm_rd_en_p   = rd_en_q;
  assign mm_wr_addr_p = wr_addr_q;
  assign mm_wr_data_p = wr_data_q;
  assign mm_wr_en_p   = wr_en_q;
  assign spi_busy_p   = busy_q;
  assign spi_err_p    = err_q;

endmodule

// File: tb/tb_fpga_spi_cmd_responder.sv
// Scoreboard bench for fpga_spi_cmd_responder: a transaction-level reference model
// pushes expected MISO words, memory-map strobes and error pulses; monitors pop and compare.
`timescale 1ns/1ps
module tb_fpga_spi_cmd_responder;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso, rd_en, wr_en, busy, err;
  logic [15:0] rd_addr, rd_data, wr_addr, wr_data;

  fpga_spi_cmd_responder #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(64)) dut (
    .clk210_p(clk), .reset_p(rst), .spi_sck_p(sck), .spi_mosi_p(mosi), .spi_ss_p(ss),
    .spi_miso_p(miso), .mm_rd_addr_p(rd_addr), .mm_rd_en_p(rd_en), .mm_rd_data_p(rd_data),
    .mm_wr_addr_p(wr_addr), .mm_wr_data_p(wr_data), .mm_wr_en_p(wr_en),
    .spi_busy_p(busy), .spi_err_p(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_miso_q[$];
  logic [31:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_err_q[$];
  logic [15:0] txw[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] mm_mem  [0:255];
  logic [15:0] rd_pipe [0:RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Memory-map model: read data valid exactly RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 16'h0000;
    end else begin
      rd_pipe[0] <= rd_en ? mm_mem[rd_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (wr_en) mm_mem[wr_addr[7:0]] <= wr_data;
    end
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  // MISO monitor: master samples on SCK rise; a full word is compared against the scoreboard.
  logic [15:0] mon_sh = 16'h0000;
  int          mon_bits = 0;
  always @(posedge sck or posedge ss) begin
    if (ss) begin
      mon_bits = 0;
    end else begin
      mon_sh = {mon_sh[14:0], miso};
      mon_bits++;
      if (mon_bits == 16) begin
        mon_bits = 0;
        if (exp_miso_q.size() == 0) unexpected("miso_word_unexpected");
        else chk("miso_word", {48'd0, mon_sh}, {48'd0, exp_miso_q.pop_front()});
      end
    end
  end

  // Strobe / error monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en && rd_en) unexpected("rd_wr_together");
    if (wr_en) begin
      if (exp_wr_q.size() == 0) unexpected("wr_strobe_unexpected");
      else chk("wr_addr_data", {32'd0, wr_addr, wr_data}, {32'd0, exp_wr_q.pop_front()});
    end
    if (rd_en) begin
      if (exp_rd_q.size() == 0) unexpected("rd_strobe_unexpected");
      else chk("rd_addr", {48'd0, rd_addr}, {48'd0, exp_rd_q.pop_front()});
    end
    if (err) begin
      if (exp_err_q.size() == 0) unexpected("err_pulse_unexpected");
      else void'(exp_err_q.pop_front());
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15-i];
      clk_n(4);
      sck = 1'b1;
      clk_n(4);
      sck = 1'b0;
    end
    clk_n(10);
  endtask

  // Reference model: walk the transaction words by the protocol rules, recording expectations.
  task automatic model_txn(input int part);
    int          ph = 0;
    logic        rd = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] resp = 16'd0;
    logic [15:0] nxt;
    logic [15:0] w;
    for (int k = 0; k < txw.size(); k++) begin
      w = txw[k];
      exp_miso_q.push_back(resp);
      nxt = 16'd0;
      if (ph == 0) begin
        if (w == 16'd1) begin ph = 1; nxt = 16'd20; end
        else begin ph = 9; nxt = 16'd27; exp_err_q.push_back(1); end
      end else if (ph == 1) begin
        if (w == 16'd2 || w == 16'd3) begin rd = (w == 16'd3); ph = 2; nxt = 16'd20; end
        else begin ph = 9; nxt = 16'd27; exp_err_q.push_back(1); end
      end else if (ph == 2) begin
        addr = w;
        ph = 3;
        if (rd) begin exp_rd_q.push_back(w); nxt = ref_mem[w[7:0]]; end
        else nxt = 16'd20;
      end else if (ph == 3) begin
        if (!rd) begin exp_wr_q.push_back({addr, w}); ref_mem[addr[7:0]] = w; end
        nxt = 16'd22;
        ph = 4;
      end else begin
        nxt = 16'd0;
        ph = 0;
      end
      resp = nxt;
    end
    if (part > 0 || ph != 0) exp_err_q.push_back(1);
  endtask

  task automatic run_txn(input int part, input logic [15:0] pw, input int stall);
    model_txn(part);
    ss = 1'b0;
    clk_n(6);
    for (int k = 0; k < txw.size(); k++) begin
      send_bits(txw[k], 16);
      if (k == 0) chk("busy_active", {63'd0, busy}, 64'd1);
    end
    if (part > 0) send_bits(pw, part);
    clk_n(stall);
    ss = 1'b1;
    clk_n(4);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    clk_n(8);
  endtask

  task automatic set_txn5(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] d, input logic [15:0] e, input int n);
    logic [15:0] v [0:4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    txw.delete();
    for (int i = 0; i < n; i++) txw.push_back(v[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          typ, k, part;
    logic [15:0] a, d;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 257) ^ 16'h5A3C;
      mm_mem[i]  = 16'(i * 257) ^ 16'h5A3C;
    end
    ref_mem[16] = 16'h1234;
    mm_mem[16]  = 16'h1234;

    clk_n(5);
    chk("reset_outs", {11'd0, miso, rd_en, wr_en, busy, err, rd_addr, wr_addr, wr_data}, 64'd0);
    rst = 1'b0;
    clk_n(5);

    set_txn5(16'd1, 16'd3, 16'h0010, 16'd0, 16'd0, 5);      run_txn(0, 16'd0, 0);
    set_txn5(16'd1, 16'd2, 16'h0010, 16'hBEEF, 16'd0, 5);   run_txn(0, 16'd0, 0);
    set_txn5(16'h0007, 16'd0, 16'd0, 16'd0, 16'd0, 2);      run_txn(0, 16'd0, 0);
    set_txn5(16'd1, 16'd2, 16'h0011, 16'hCAFE, 16'd0, 5);   run_txn(0, 16'd0, 0);
    set_txn5(16'd1, 16'd3, 16'h0010, 16'd0, 16'd0, 5);      run_txn(0, 16'd0, 0);
    set_txn5(16'd1, 16'h0009, 16'd0, 16'd0, 16'd0, 3);     run_txn(0, 16'd0, 0);
    set_txn5(16'd1, 16'd2, 16'h0020, 16'd0, 16'd0, 3);      run_txn(9, 16'h5555, 0);

    for (int n = 0; n < 24; n++) begin
      typ = int'($urandom_range(0, 4));
      a   = 16'($urandom_range(0, 255));
      d   = 16'($urandom);
      part = 0;
      case (typ)
        0: set_txn5(16'd1, 16'd2, a, d, 16'd0, 5);
        1: set_txn5(16'd1, 16'd3, a, 16'd0, 16'd0, 5);
        2: set_txn5(16'($urandom_range(4, 65535)), 16'd0, 16'd0, 16'd0, 16'd0, 2);
        3: set_txn5(16'd1, 16'($urandom_range(4, 255)), 16'd0, 16'd0, 16'd0, 3);
        default: begin
          k = int'($urandom_range(0, 4));
          part = int'($urandom_range(1, 15));
          set_txn5(16'd1, ($urandom_range(0, 1) != 0) ? 16'd2 : 16'd3, a, d, 16'd0, k);
        end
      endcase
      run_txn(part, d, 0);
    end

`ifdef SPI_RESP_TIMEOUT_EN
    set_txn5(16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 2);
    run_txn(5, 16'h00F0, 150);
`endif

    // Reset in the middle of the address word: state discarded, outputs cleared.
    exp_miso_q.push_back(16'd0);
    exp_miso_q.push_back(16'd20);
    ss = 1'b0;
    clk_n(6);
    send_bits(16'd1, 16);
    send_bits(16'd2, 16);
    send_bits(16'h0033, 6);
    rst = 1'b1;
    clk_n(2);
    chk("reset_mid_outs", {11'd0, miso, rd_en, wr_en, busy, err, rd_addr, wr_addr, wr_data}, 64'd0);
    ss = 1'b1;
    clk_n(3);
    rst = 1'b0;
    clk_n(10);
    chk("after_reset_busy", {63'd0, busy}, 64'd0);

    set_txn5(16'd1, 16'd3, 16'h0011, 16'd0, 16'd0, 5);
    run_txn(0, 16'd0, 0);

    clk_n(20);
    chk("miso_q_empty", 64'(exp_miso_q.size()), 64'd0);
    chk("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("err_q_empty", 64'(exp_err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
